// File: rtl/intdiv.sv
// Sequential restoring divider: 2*AW-bit dividend by AW-bit divisor, one operation in flight.
// Define INTDIV_RADIX4_EN to retire two quotient bits per cycle instead of one.
module intdiv #(
  parameter int AW = 255
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [2*AW-1:0] dividend,
  input  logic [AW-1:0]   divisor,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [2*AW-1:0] quotient,
  output logic [AW-1:0]   remainder,
  output logic            div_by_zero
);

  localparam int DW = 2 * AW;
`ifdef INTDIV_RADIX4_EN
  localparam int SPC = 2;
`else
  localparam int SPC = 1;
`endif
  localparam int STEPS = DW / SPC;
  localparam int CW = $clog2(STEPS + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(STEPS - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // One restoring step: returns {quotient bit, new partial remainder}.
  // pr[AW] never survives a step, but folding it into the compare keeps the step exact.
  function automatic logic [AW+1:0] rstep(input logic [AW:0] pr, input logic din,
                                          input logic [AW-1:0] dsr);
    logic [AW:0] t;
    t = {pr[AW-1:0], din};
    if (pr[AW] || (t >= {1'b0, dsr})) begin
      rstep = {1'b1, t - {1'b0, dsr}};
    end else begin
      rstep = {1'b0, t};
    end
  endfunction

  state_t          state_r, state_s;
  logic [DW-1:0]   den_r, den_s;
  logic [AW-1:0]   dsr_r, dsr_s;
  logic [AW:0]     pr_r, pr_s;
  logic [DW-1:0]   q_r, q_s;
  logic [CW-1:0]   cnt_r, cnt_s;
  logic [DW-1:0]   quotient_r, quotient_s;
  logic [AW-1:0]   remainder_r, remainder_s;
  logic            dbz_r, dbz_s;
  logic            out_valid_r, out_valid_s;
  logic            in_ready_r, in_ready_s;

  logic [AW+1:0]   s1_s;
  logic [AW:0]     pr_step_s;
  logic [DW-1:0]   q_step_s;
  logic [DW-1:0]   den_step_s;

  // Datapath for one RUN cycle, consuming dividend bits MSB first.
`ifdef INTDIV_RADIX4_EN
  logic [AW+1:0]   s2_s;
  always_comb begin
    s1_s       = rstep(pr_r, den_r[DW-1], dsr_r);
    s2_s       = rstep(s1_s[AW:0], den_r[DW-2], dsr_r);
    pr_step_s  = s2_s[AW:0];
    q_step_s   = {q_r[DW-3:0], s1_s[AW+1], s2_s[AW+1]};
    den_step_s = {den_r[DW-3:0], 2'b00};
  end
`else
  always_comb begin
    s1_s       = rstep(pr_r, den_r[DW-1], dsr_r);
    pr_step_s  = s1_s[AW:0];
    q_step_s   = {q_r[DW-2:0], s1_s[AW+1]};
    den_step_s = {den_r[DW-2:0], 1'b0};
  end
`endif

  // Next-state and next-register logic for the control FSM.
  always_comb begin
    state_s     = state_r;
    den_s       = den_r;
    dsr_s       = dsr_r;
    pr_s        = pr_r;
    q_s         = q_r;
    cnt_s       = cnt_r;
    quotient_s  = quotient_r;
    remainder_s = remainder_r;
    dbz_s       = dbz_r;
    out_valid_s = out_valid_r;
    in_ready_s  = in_ready_r;
    case (state_r)
      IDLE: begin
        if (in_valid && in_ready_r) begin
          den_s      = dividend;
          dsr_s      = divisor;
          pr_s       = {(AW+1){1'b0}};
          q_s        = {DW{1'b0}};
          cnt_s      = {CW{1'b0}};
          in_ready_s = 1'b0;
          if (divisor == {AW{1'b0}}) begin
            state_s     = DONE;
            quotient_s  = {DW{1'b1}};
            remainder_s = {AW{1'b0}};
            dbz_s       = 1'b1;
          end else begin
            state_s = RUN;
          end
        end else begin
          in_ready_s = 1'b1;
        end
      end
      RUN: begin
        den_s = den_step_s;
        pr_s  = pr_step_s;
        q_s   = q_step_s;
        if (cnt_r == CNT_LAST) begin
          state_s     = DONE;
          cnt_s       = {CW{1'b0}};
          quotient_s  = q_step_s;
          remainder_s = pr_step_s[AW-1:0];
          dbz_s       = 1'b0;
          out_valid_s = 1'b1;
        end else begin
          cnt_s = cnt_r + CW'(1);
        end
      end
      DONE: begin
        // Divide-by-zero arrives here with out_valid still low; raise it one cycle later.
        if (!out_valid_r) begin
          out_valid_s = 1'b1;
        end else if (out_ready) begin
          state_s     = IDLE;
          out_valid_s = 1'b0;
          in_ready_s  = 1'b1;
        end else begin
          out_valid_s = 1'b1;
        end
      end
      default: begin
        state_s     = IDLE;
        cnt_s       = {CW{1'b0}};
        out_valid_s = 1'b0;
        in_ready_s  = 1'b1;
      end
    endcase
  end

  // State and datapath registers with asynchronous reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r     <= IDLE;
      den_r       <= {DW{1'b0}};
      dsr_r       <= {AW{1'b0}};
      pr_r        <= {(AW+1){1'b0}};
      q_r         <= {DW{1'b0}};
      cnt_r       <= {CW{1'b0}};
      quotient_r  <= {DW{1'b0}};
      remainder_r <= {AW{1'b0}};
      dbz_r       <= 1'b0;
      out_valid_r <= 1'b0;
      in_ready_r  <= 1'b1;
    end else begin
      state_r     <= state_s;
      den_r       <= den_s;
      dsr_r       <= dsr_s;
      pr_r        <= pr_s;
      q_r         <= q_s;
      cnt_r       <= cnt_s;
      quotient_r  <= quotient_s;
      remainder_r <= remainder_s;
      dbz_r       <= dbz_s;
      out_valid_r <= out_valid_s;
      in_ready_r  <= in_ready_s;
    end
  end

  assign in_ready    = in_ready_r;
  assign out_valid   = out_valid_r;
  assign quotient    = quotient_r;
  assign remainder   = remainder_r;
  assign div_by_zero = dbz_r;

endmodule
